instr_word_encoder: RTL and testbench

//  Inverse of the immediate generator: packs decoded RISC-V fields plus a 32-bit immediate into a 32-bit instruction word.

---
 rtl/instr_word_encoder.sv | 188 ++++++++++++++++++
 tb/tb_instr_word_encoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_word_encoder.sv
// Packs decoded RISC-V fields and an immediate into a 32-bit instruction word (2-stage valid/ready pipe).
// Optional build macro ENC_ROUNDTRIP_CHECK_EN adds out_mismatch, a re-extraction check of the placed immediate.
module instr_word_encoder #(
    parameter int unsigned ERR_CNT_W = 16,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef ENC_ROUNDTRIP_CHECK_EN
    ,
    output logic                 out_mismatch
`endif
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic        s1_valid_reg;
    logic [2:0]  s1_fmt_reg;
    logic [6:0]  s1_opcode_reg;
    logic [4:0]  s1_rd_reg;
    logic [4:0]  s1_rs1_reg;
    logic [4:0]  s1_rs2_reg;
    logic [2:0]  s1_funct3_reg;
    logic [6:0]  s1_funct7_reg;
    logic [31:0] s1_imm_reg;
    logic        s1_legal_reg;

    logic                 out_valid_reg;
    logic [31:0]          out_instr_reg;
    logic                 out_err_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;

    logic        legal_next;
    logic        s2_ready;
    logic        s2_load;
    logic [31:0] enc_word;

    // An immediate fits a signed n-bit field when all bits from n-1 upward agree.
    logic fits12;
    logic fits13;
    logic fits21;

    assign fits12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
    assign fits13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
    assign fits21 = (&in_imm[31:20]) || (~|in_imm[31:20]);

    always_comb begin
        legal_next = 1'b0;
        case (in_fmt)
            FMT_R:   legal_next = 1'b1;
            FMT_I:   legal_next = fits12;
            FMT_S:   legal_next = fits12;
            FMT_B:   legal_next = fits13 && !in_imm[0];
            FMT_U:   legal_next = ~|in_imm[11:0];
            FMT_J:   legal_next = fits21 && !in_imm[0];
            default: legal_next = 1'b0;
        endcase
    end

    assign s2_ready = !out_valid_reg || out_ready;
    assign s2_load  = s1_valid_reg && s2_ready;
    assign in_ready = !s1_valid_reg || s2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_fmt_reg    <= in_fmt;
            s1_opcode_reg <= in_opcode;
            s1_rd_reg     <= in_rd;
            s1_rs1_reg    <= in_rs1;
            s1_rs2_reg    <= in_rs2;
            s1_funct3_reg <= in_funct3;
            s1_funct7_reg <= in_funct7;
            s1_imm_reg    <= in_imm;
            s1_legal_reg  <= legal_next;
        end
    end

    // Field bits a format does not use stay zero because each arm builds the whole word.
    always_comb begin
        enc_word = NOP_WORD;
        if (s1_legal_reg) begin
            case (s1_fmt_reg)
                FMT_R: enc_word = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                                   s1_rd_reg, s1_opcode_reg};
                FMT_I: enc_word = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                                   s1_rd_reg, s1_opcode_reg};
                FMT_S: enc_word = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                                   s1_imm_reg[4:0], s1_opcode_reg};
                FMT_B: enc_word = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg,
                                   s1_funct3_reg, s1_imm_reg[4:1], s1_imm_reg[11], s1_opcode_reg};
                FMT_U: enc_word = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
                FMT_J: enc_word = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                   s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
                default: enc_word = NOP_WORD;
            endcase
        end
    end

    // The error counter moves when a rejected word enters S2, so a stalled word counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'h0;
            out_err_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (s2_ready) begin
                out_valid_reg <= s1_valid_reg;
            end
            if (s2_load) begin
                out_instr_reg <= enc_word;
                out_err_reg   <= !s1_legal_reg;
                if (!s1_legal_reg && (err_count_reg != {ERR_CNT_W{1'b1}})) begin
                    err_count_reg <= err_count_reg + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_err   = out_err_reg;
    assign err_count = err_count_reg;

`ifdef ENC_ROUNDTRIP_CHECK_EN
    logic [31:0] rt_imm;
    logic        mismatch_next;
    logic        mismatch_reg;

    // Decode the immediate back out of the word exactly as the immediate generator would.
    always_comb begin
        rt_imm        = 32'h0;
        mismatch_next = 1'b0;
        case (s1_fmt_reg)
            FMT_I: rt_imm = {{20{enc_word[31]}}, enc_word[31:20]};
            FMT_S: rt_imm = {{20{enc_word[31]}}, enc_word[31:25], enc_word[11:7]};
            FMT_B: rt_imm = {{19{enc_word[31]}}, enc_word[31], enc_word[7],
                             enc_word[30:25], enc_word[11:8], 1'b0};
            FMT_U: rt_imm = {enc_word[31:12], 12'h000};
            FMT_J: rt_imm = {{11{enc_word[31]}}, enc_word[31], enc_word[19:12],
                             enc_word[20], enc_word[30:21], 1'b0};
            default: rt_imm = 32'h0;
        endcase
        if (s1_legal_reg && (s1_fmt_reg != FMT_R)) begin
            mismatch_next = (rt_imm != s1_imm_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_reg <= 1'b0;
        end else if (s2_load) begin
            mismatch_reg <= mismatch_next;
        end
    end

    assign out_mismatch = mismatch_reg;
`endif

endmodule

// File: tb/tb_instr_word_encoder.sv
// Scoreboard bench for instr_word_encoder: the driver queues hand-computed words, a monitor pops on each handshake.
module tb_instr_word_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;
`ifdef ENC_ROUNDTRIP_CHECK_EN
    logic        out_mismatch;
`endif

    always #5 clk = ~clk;

    instr_word_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
`ifdef ENC_ROUNDTRIP_CHECK_EN
        ,
        .out_mismatch (out_mismatch)
`endif
    );

    typedef struct {
        int          id;
        logic [31:0] instr;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;
    bit          in_reset = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input int id, input logic [2:0] fmt, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
        exp_t e;
        int   n;
        @(negedge clk);
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        if (exp_err) exp_cnt = exp_cnt + 16'd1;
        e.id    = id;
        e.instr = exp_instr;
        e.err   = exp_err;
        e.cnt   = exp_cnt;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout id=%0d: in_ready=0 after %0d cycles, expected 1", id, n);
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: pops one expectation per output handshake and checks held words while stalled.
    initial begin
        logic        hold_v;
        logic [31:0] hold_i;
        hold_v = 1'b0;
        hold_i = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (in_reset) begin
                hold_v = 1'b0;
                continue;
            end
            if (hold_v) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_instr", out_instr, hold_i);
            end
            hold_v = out_valid && !out_ready;
            hold_i = out_instr;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%08h, expected no word", out_instr);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("txn %0d: instr=0x%08h err=%0d err_count=%0d", mon_e.id, out_instr,
                             out_err, err_count);
                    chk($sformatf("instr_%0d", mon_e.id), out_instr, mon_e.instr);
                    chk($sformatf("err_%0d", mon_e.id), 32'(out_err), 32'(mon_e.err));
                    chk($sformatf("err_count_%0d", mon_e.id), 32'(err_count), 32'(mon_e.cnt));
`ifdef ENC_ROUNDTRIP_CHECK_EN
                    chk($sformatf("mismatch_%0d", mon_e.id), 32'(out_mismatch), 32'd0);
`endif
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_fmt    = 3'd0;
        in_opcode = 7'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_funct7 = 7'd0;
        in_imm    = 32'd0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst      = 1'b0;
        in_reset = 1'b0;

        // Legal encodings, including range boundaries and ignored fields.
        send(1,  3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2,          32'h00210093, 1'b0);
        send(2,  3'd1, 7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4,          32'h00412083, 1'b0);
        send(3,  3'd2, 7'h23, 5'd5, 5'd2, 5'd1, 3'd2, 7'd0, 32'd8,          32'h00112423, 1'b0);
        send(4,  3'd3, 7'h63, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE208EE3, 1'b0);
        send(5,  3'd4, 7'h37, 5'd1, 5'd3, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h123450B7, 1'b0);
        send(6,  3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h402081B3, 1'b0);
        send(7,  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h008000EF, 1'b0);
        send(8,  3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFE,  32'hFFFFF06F, 1'b0);
        send(9,  3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE,  32'h7FFFF06F, 1'b0);
        send(10, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,       32'h7E000FE3, 1'b0);
        send(11, 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,  32'h80000013, 1'b0);
        send(12, 3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,  32'h80000023, 1'b0);
        send(13, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000,  32'h80000063, 1'b0);

        // Rejected requests: every one emits the NOP word and bumps the counter.
        send(20, 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h00000013, 1'b1);
        send(21, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          32'h00000013, 1'b1);
        send(22, 3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,          32'h00000013, 1'b1);
        send(23, 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001,  32'h00000013, 1'b1);
        send(24, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000,  32'h00000013, 1'b1);
        send(25, 3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,          32'h00000013, 1'b1);
        send(26, 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd2048,       32'h00000013, 1'b1);
        send(27, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,       32'h00000013, 1'b1);
        idle();
        drain("drain_directed");

        // Back-to-back requests against a consumer that stalls for several cycles.
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    send(30 + k, 3'd1, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k),
                         {12'(k), 5'd0, 3'd0, 5'(k), 7'h13}, 1'b0);
                end
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                #3;
                chk("stall_in_ready_low", 32'(in_ready), 32'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Fill both stages with rejected words, then reset in the middle of the stall.
        @(negedge clk);
        out_ready = 1'b0;
        send(40, 3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
        send(41, 3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk("stalled_err_count_once", 32'(err_count), 32'd9);
        chk("full_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_reset = 1'b1;
        rst      = 1'b1;
        sb_q.delete();
        exp_cnt  = 16'd0;
        @(negedge clk);
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_err_count", 32'(err_count), 32'd0);
        chk("midreset_out_err", 32'(out_err), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_reset  = 1'b0;

        // First accept after reset must appear after the second edge.
        send(50, 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00210093, 1'b0);
        idle();
        #1;
        chk("latency_edge1_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("latency_edge2_out_valid", 32'(out_valid), 32'd1);
        drain("drain_after_reset");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
